// File: rtl/cpu_idu.sv
// +-----------------------------------------------------------------------------+
// | cpu_idu : RV32I decode/issue stage for the ALU-class subset, with RAW       |
// |           hazard bubbles and an optional WB-to-operand forward (IDU_FWD_EN).|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

`ifndef ALU_ADD
`define ALU_ADD 5'd0
`define ALU_SUB 5'd1
`define ALU_SLL 5'd2
`define ALU_LT  5'd3
`define ALU_LTU 5'd4
`define ALU_XOR 5'd5
`define ALU_SRL 5'd6
`define ALU_SRA 5'd7
`define ALU_OR  5'd8
`define ALU_AND 5'd9
`define ALU_EQ  5'd10
`define ALU_NE  5'd11
`define ALU_GE  5'd12
`define ALU_GEU 5'd13
`endif

module cpu_idu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_flag,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] exu_out,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic        wait_exe,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic        ill_inst
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        wb_haz1;
  logic        wb_haz2;

  logic        dec_legal;
  logic        dec_use1;
  logic        dec_use2;
  logic        dec_we;
  logic [4:0]  dec_alu;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;

  logic        hazard;
  logic        stall;
  logic        xfer;

  logic [4:0]  alu_d,  alu_q;
  logic [31:0] in1_d,  in1_q;
  logic [31:0] in2_d,  in2_q;
  logic        wait_d, wait_q;
  logic [4:0]  rd_d,   rd_q;
  logic        we_d,   we_q;
  logic        ill_d,  ill_q;
  logic [4:0]  wb_rd_q;
  logic        wb_we_q;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_u    = {inst[31:12], 12'b0};

`ifdef IDU_FWD_EN
  // A WB match is served from the execution result instead of stalling.
  assign src1    = (rs1_addr != 5'd0 && wb_we_q && wb_rd_q == rs1_addr) ? exu_out : rs1_data;
  assign src2    = (rs2_addr != 5'd0 && wb_we_q && wb_rd_q == rs2_addr) ? exu_out : rs2_data;
  assign wb_haz1 = 1'b0;
  assign wb_haz2 = 1'b0;
`else
  logic unused_exu;
  assign unused_exu = ^exu_out;
  assign src1       = rs1_data;
  assign src2       = rs2_data;
  assign wb_haz1    = wb_we_q && (wb_rd_q == rs1_addr);
  assign wb_haz2    = wb_we_q && (wb_rd_q == rs2_addr);
`endif

  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? `ALU_SUB : `ALU_ADD;
      3'b001:  alu_of = `ALU_SLL;
      3'b010:  alu_of = `ALU_LT;
      3'b011:  alu_of = `ALU_LTU;
      3'b100:  alu_of = `ALU_XOR;
      3'b101:  alu_of = alt ? `ALU_SRA : `ALU_SRL;
      3'b110:  alu_of = `ALU_OR;
      default: alu_of = `ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b1;
    dec_use1  = 1'b0;
    dec_use2  = 1'b0;
    dec_we    = 1'b0;
    dec_alu   = `ALU_ADD;
    dec_in1   = '0;
    dec_in2   = '0;
    case (opcode)
      OPC_OP: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_we   = 1'b1;
        dec_alu  = alu_of(funct3, inst[30]);
        dec_in1  = src1;
        dec_in2  = src2;
      end
      OPC_OPIMM: begin
        // funct7[5] only distinguishes SRAI from SRLI; ADDI never subtracts.
        dec_use1 = 1'b1;
        dec_we   = 1'b1;
        dec_alu  = alu_of(funct3, (funct3 == 3'b101) && inst[30]);
        dec_in1  = src1;
        dec_in2  = imm_i;
      end
      OPC_LUI: begin
        dec_we  = 1'b1;
        dec_in2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_we  = 1'b1;
        dec_in1 = pc;
        dec_in2 = imm_u;
      end
      OPC_BRANCH: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_in1  = src1;
        dec_in2  = src2;
        case (funct3)
          3'b000:  dec_alu = `ALU_EQ;
          3'b001:  dec_alu = `ALU_NE;
          3'b100:  dec_alu = `ALU_LT;
          3'b101:  dec_alu = `ALU_GE;
          3'b110:  dec_alu = `ALU_LTU;
          3'b111:  dec_alu = `ALU_GEU;
          default: begin
            dec_legal = 1'b0;
            dec_use1  = 1'b0;
            dec_use2  = 1'b0;
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign hazard = (dec_use1 && rs1_addr != 5'd0 && ((we_q && rd_q == rs1_addr) || wb_haz1)) ||
                  (dec_use2 && rs2_addr != 5'd0 && ((we_q && rd_q == rs2_addr) || wb_haz2));
  assign stall      = inst_valid && hazard && !flush_flag;
  assign inst_ready = rst_n && !stall;
  assign xfer       = inst_valid && inst_ready && !flush_flag;

  always_comb begin
    alu_d  = `ALU_ADD;
    in1_d  = '0;
    in2_d  = '0;
    wait_d = 1'b1;
    rd_d   = 5'd0;
    we_d   = 1'b0;
    ill_d  = 1'b0;
    if (xfer) begin
      if (dec_legal) begin
        alu_d  = dec_alu;
        in1_d  = dec_in1;
        in2_d  = dec_in2;
        wait_d = 1'b0;
        rd_d   = dec_we ? inst[11:7] : 5'd0;
        we_d   = dec_we;
      end else begin
        ill_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_q   <= `ALU_ADD;
      in1_q   <= '0;
      in2_q   <= '0;
      wait_q  <= 1'b1;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      wb_rd_q <= 5'd0;
      wb_we_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
      wb_rd_q <= rd_q;
      wb_we_q <= we_q;
    end
  end

  assign alu_ctrl = alu_q;
  assign in1      = in1_q;
  assign in2      = in2_q;
  assign wait_exe = wait_q;
  assign rd_addr  = rd_q;
  assign rd_we    = we_q;
  assign ill_inst = ill_q;

endmodule

`default_nettype wire
